timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 131 +++++++++++++
 tb/tb_timer_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one shared N-bit interval counter to R requesters.
// A granted requester is timed up to its latched ceiling and then receives a one-cycle done pulse.
module timer_arbiter #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] ceiling,
    input  logic           abort,
    output logic [R-1:0]   gnt,
    output logic [R-1:0]   done,
    output logic           busy,
    output logic [N-1:0]   count
);

    localparam int IW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t        state_reg;
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] idx_reg;
    logic [N-1:0]  ceil_reg;
    logic [N-1:0]  count_reg;
    logic [R-1:0]  gnt_reg;
    logic [R-1:0]  done_reg;
    logic          hold_reg;   // forces one idle cycle after every interval ends

    logic [N-1:0]  ceil_slice [R];
    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] idx_inc;

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_slice
            assign ceil_slice[gi] = ceiling[gi*N +: N];
        end
    endgenerate

    // First requesting index at or above ptr, wrapping past R-1 back to 0.
    always_comb begin : p_pick
        int            j;
        logic [IW-1:0] jx;
        found = 1'b0;
        win   = '0;
        j     = 0;
        jx    = '0;
        for (int k = 0; k < R; k++) begin
            j = int'(ptr_reg) + k;
            if (j >= R) begin
                j = j - R;
            end
            jx = IW'(j);
            if (!found && req[jx]) begin
                found = 1'b1;
                win   = jx;
            end
        end
    end

    assign idx_inc = (idx_reg == IW'(R - 1)) ? '0 : idx_reg + IW'(1);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            idx_reg   <= '0;
            ceil_reg  <= '0;
            count_reg <= '0;
            gnt_reg   <= '0;
            done_reg  <= '0;
            hold_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= '0;
                    if (hold_reg) begin
                        hold_reg <= 1'b0;
                    end else if (!abort && found) begin
                        idx_reg   <= win;
                        ceil_reg  <= ceil_slice[win];
                        count_reg <= '0;
                        gnt_reg   <= R'(1) << win;
                        state_reg <= COUNT;
                    end
                end
                COUNT: begin
                    if (abort || !req[idx_reg]) begin
                        state_reg <= IDLE;
                        gnt_reg   <= '0;
                        count_reg <= '0;
                        ptr_reg   <= idx_inc;
                        hold_reg  <= 1'b1;
                    end else if (count_reg == ceil_reg) begin
                        state_reg <= FINISH;
                        done_reg  <= gnt_reg;
                    end else begin
                        count_reg <= count_reg + N'(1);
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                    done_reg  <= '0;
                    count_reg <= '0;
                    ptr_reg   <= idx_inc;
                    hold_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                    done_reg  <= '0;
                    count_reg <= '0;
                end
            endcase
        end
    end

    // An abort arriving during FINISH must still suppress the pulse, so it gates the output directly.
    assign done  = done_reg & ~{R{abort}};
    assign gnt   = gnt_reg;
    assign busy  = (state_reg != IDLE);
    assign count = count_reg;

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomized and directed checks of timer_arbiter against a job-age reference model.
// Each granted interval is modelled by its age in cycles; outputs follow from age and ceiling.
module tb_timer_arbiter;

    localparam int N  = 8;
    localparam int R  = 4;
    localparam int IW = 2;

    logic           clk;
    logic           n_reset;
    logic [R-1:0]   req_v;
    logic [N-1:0]   ceil_a [R];
    logic [R*N-1:0] ceil_v;
    logic           abort_v;
    logic [R-1:0]   gnt;
    logic [R-1:0]   done;
    logic           busy;
    logic [N-1:0]   count;

    int checks = 0;
    int errors = 0;

    // reference model: one job at a time, described by owner, ceiling and age
    int m_active;
    int m_idx;
    int m_ceil;
    int m_age;
    int m_ptr;
    int m_cool;

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_ceil
            assign ceil_v[gi*N +: N] = ceil_a[gi];
        end
    endgenerate

    timer_arbiter #(.N(N), .R(R)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .req     (req_v),
        .ceiling (ceil_v),
        .abort   (abort_v),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_gnt();
        return (m_active != 0) ? (32'd1 << m_idx) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_count();
        if (m_active == 0) return 32'd0;
        return (m_age < m_ceil) ? 32'(m_age) : 32'(m_ceil);
    endfunction

    function automatic logic [31:0] exp_done();
        if (m_active != 0 && m_age == m_ceil + 1 && !abort_v) return 32'd1 << m_idx;
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_idx    = 0;
        m_ceil   = 0;
        m_age    = 0;
        m_ptr    = 0;
        m_cool   = 0;
    endtask

    // Advance the model across one rising edge using the inputs present at that edge.
    task automatic model_edge();
        int ended;
        int cancelled;
        int j;
        ended     = 0;
        cancelled = 0;
        if (m_active != 0) begin
            if (m_age <= m_ceil) begin
                if (abort_v || !req_v[IW'(m_idx)]) cancelled = 1;
                else m_age++;
            end else begin
                ended = 1;
            end
            if (ended != 0 || cancelled != 0) begin
                $display("txn: requester %0d ceiling %0d %s after %0d gnt cycles",
                         m_idx, m_ceil, (cancelled != 0) ? "cancelled" : "completed", m_age + 1);
                m_active = 0;
                m_ptr    = (m_idx + 1) % R;
                m_cool   = 1;
            end
        end else if (m_cool != 0) begin
            m_cool = 0;
        end else if (!abort_v && req_v != '0) begin
            for (int k = R - 1; k >= 0; k--) begin
                j = (m_ptr + k) % R;
                if (req_v[IW'(j)]) m_idx = j;
            end
            m_active = 1;
            m_age    = 0;
            m_ceil   = int'(ceil_a[IW'(m_idx)]);
        end
    endtask

    task automatic check_outputs();
        check("gnt", 32'(gnt), exp_gnt());
        check("done", 32'(done), exp_done());
        check("busy", 32'(busy), 32'(m_active != 0));
        check("count", 32'(count), exp_count());
    endtask

    // Inputs are set by the caller shortly after an edge; outputs are checked, then one edge passes.
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drain(input int n);
        req_v   = '0;
        abort_v = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_reset = 1'b0;
        req_v   = '0;
        abort_v = 1'b0;
        for (int i = 0; i < R; i++) ceil_a[i] = '0;
        model_reset();
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        n_reset = 1'b1;

        // single requester, ceiling 3
        ceil_a[0] = 8'd3;
        req_v     = 4'b0001;
        for (int i = 0; i < 8; i++) tick();
        drain(2);

        // round robin with all ceilings zero
        for (int i = 0; i < R; i++) ceil_a[i] = '0;
        req_v = 4'b1111;
        for (int i = 0; i < 16; i++) tick();
        drain(2);

        // full-scale ceiling, then zero ceiling, on requester 1
        ceil_a[1] = 8'd255;
        req_v     = 4'b0010;
        for (int i = 0; i < 262; i++) tick();
        ceil_a[1] = 8'd0;
        for (int i = 0; i < 5; i++) tick();
        drain(2);

        // abort in the same cycle count reaches the ceiling
        ceil_a[2] = 8'd2;
        req_v     = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            abort_v = (m_active != 0 && m_age == m_ceil);
            tick();
        end
        abort_v = 1'b0;
        for (int i = 0; i < R; i++) ceil_a[i] = '0;
        req_v = 4'b1111;
        for (int i = 0; i < 6; i++) tick();
        drain(2);

        // requester 2 withdraws at count 4 of ceiling 10, then ptr should favour 3
        ceil_a[2] = 8'd10;
        req_v     = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            if (m_active != 0 && m_idx == 2 && m_age == 4) req_v = 4'b0000;
            tick();
        end
        for (int i = 0; i < R; i++) ceil_a[i] = '0;
        req_v = 4'b1111;
        for (int i = 0; i < 6; i++) tick();
        drain(2);

        // asynchronous reset in the middle of an interval
        ceil_a[0] = 8'd20;
        req_v     = 4'b0001;
        for (int i = 0; i < 6; i++) tick();
        #2;
        n_reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #1;
        n_reset = 1'b1;
        ceil_a[1] = 8'd1;
        ceil_a[3] = 8'd1;
        req_v     = 4'b1010;
        for (int i = 0; i < 8; i++) tick();
        drain(2);

        // randomized traffic, with ceilings changing under running intervals
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < R; b++) begin
                if ($urandom_range(0, 11) == 0) req_v[b] = ~req_v[b];
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 31) == 0) ceil_a[b] = N'($urandom_range(0, 40));
                    else ceil_a[b] = N'($urandom_range(0, 7));
                end
            end
            abort_v = ($urandom_range(0, 39) == 0);
            tick();
        end
        drain(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
